// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit blocks.
// Holds the FSM state encoding, parity mode codes and the frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Line bits per frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_param_baud.sv
// Oversample tick generator: CLK_DIV-1 down to 0, one-cycle tick on 0, then reload.
// Tick is the cycle after enable by CLK_DIV clocks; held at reload while disabled.
module uart_baud_tick #(
  parameter int CLK_DIV = 217
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == '0)) cnt_d = RELOAD;
    else                        cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 tick voting per bit.
// valid rises 1 clk after the final stop tick; held until ready, frames arriving meanwhile pulse overrun.
module uart_rx_param #(
  parameter int CLK_DIV   = 217,
  parameter int OVS       = 12,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  import uart_pkg::*;

  localparam int PH_W  = $clog2(OVS);
  localparam int BIT_W = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));
  localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0]  PH_END    = PH_W'(OVS - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxs, tick, bit_val, sample, last_stop, ferr_now;
  state_e               state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 valid_q, valid_d, perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d, ovr_q, ovr_d;

  assign rxs = sync_q[1];

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // rxs at the previous two ticks; voting with the current value rejects one-tick glitches.
  logic [1:0] hist_q;
  always_ff @(posedge Clock) begin
    if (Reset)     hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rxs};
  end
  assign bit_val = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign bit_val = rxs;
`endif

  always_comb begin
    sample = 1'b0;
    case (state_q)
      START:                        sample = tick && (ph_q == PH_MID);
      DATA, uart_pkg::PARITY, STOP: sample = tick && (ph_q == PH_END);
      default:                      sample = 1'b0;
    endcase
  end

  assign last_stop = sample && (state_q == STOP) && (bit_q == LAST_STOP);
  assign ferr_now  = ferr_q | ~bit_val;

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (!rxs) state_d = START;
      START:            if (sample) state_d = bit_val ? IDLE : DATA;
      DATA:             if (sample && (bit_q == LAST_DATA))
                          state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (sample) state_d = STOP;
      STOP:             if (last_stop) state_d = ferr_now ? BREAK : IDLE;
      BREAK:            if (rxs) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_comb begin
    ph_d       = ph_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    if (state_q == IDLE) begin
      ph_d   = '0;
      bit_d  = '0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end else if (tick) begin
      ph_d = sample ? '0 : ph_q + 1'b1;
    end
    if (sample) begin
      case (state_q)
        DATA: begin
          sh_d  = {bit_val, sh_q[DATA_BITS-1:1]};
          bit_d = (bit_q == LAST_DATA) ? '0 : bit_q + 1'b1;
        end
        uart_pkg::PARITY: perr_d = (PARITY == PAR_ODD) ? ~(^sh_q ^ bit_val) : (^sh_q ^ bit_val);
        STOP: begin
          ferr_d = ferr_now;
          bit_d  = bit_q + 1'b1;
        end
        default: ;
      endcase
    end
    if (valid_q && ready) valid_d = 1'b0;
    // A completed frame only lands if the held word is empty or leaving this cycle.
    if (last_stop) begin
      if (!valid_q || ready) begin
        data_d     = sh_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_now;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q     <= 2'b11;
      ph_q       <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX};
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E2 instance driven with directed
// vector rows, multi-cycle corner sequences and random frames scored against a frame model.
module tb_uart_rx_param;

  localparam int N_CD = 2, N_OVS = 12;
  localparam int P_CD = 3, P_OVS = 8;
  localparam int GK_BIT3 = N_OVS / 2 + 4 * N_OVS;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'hF0;
`else
  localparam logic [7:0] GLITCH_EXP = 8'hF8;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic rx_n = 1'b1, rx_p = 1'b1, rdy_n = 1'b1, rdy_p = 1'b1;
  logic [7:0] data_n, data_p;
  logic vld_n, vld_p, pe_n, pe_p, fe_n, fe_p, ov_n, ov_p;

  always #5 Clock = ~Clock;

  uart_rx_param #(.CLK_DIV(N_CD), .OVS(N_OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .Clock(Clock), .Reset(Reset), .RX(rx_n), .data(data_n), .valid(vld_n), .ready(rdy_n),
    .parity_err(pe_n), .frame_err(fe_n), .overrun(ov_n));

  uart_rx_param #(.CLK_DIV(P_CD), .OVS(P_OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_p (
    .Clock(Clock), .Reset(Reset), .RX(rx_p), .data(data_p), .valid(vld_p), .ready(rdy_p),
    .parity_err(pe_p), .frame_err(fe_p), .overrun(ov_p));

  typedef struct packed { logic [7:0] d; logic pe; logic fe; } rec_t;
  typedef struct {
    bit sel; logic [7:0] d; bit pflip; logic [1:0] stops; int gk;
    logic [7:0] exp_d; bit exp_pe; bit exp_fe;
  } vec_t;

  rec_t got_n[$], got_p[$];
  int vcyc_n = 0, ovr_n = 0, ovr_p = 0;
  int checks = 0, errors = 0;

  // Handshakes and pulses observed mid-cycle, away from the active edge.
  always @(negedge Clock) begin
    if (vld_n && rdy_n) got_n.push_back(rec_t'{d: data_n, pe: pe_n, fe: fe_n});
    if (vld_p && rdy_p) got_p.push_back(rec_t'{d: data_p, pe: pe_p, fe: fe_p});
    if (vld_n) vcyc_n++;
    if (ov_n) ovr_n++;
    if (ov_p) ovr_p++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx_n = v;
  endtask

  task automatic idle(input bit sel, input int n);
    drive(sel, 1'b1);
    repeat (n) step();
  endtask

  function automatic int qsize(input bit sel);
    return sel ? got_p.size() : got_n.size();
  endfunction

  function automatic rec_t first(input bit sel);
    return sel ? got_p[0] : got_n[0];
  endfunction

  // Drives one frame, one line bit per CLK_DIV*OVS clocks; gk>0 inverts the
  // CLK_DIV clocks feeding the synchronised sample at oversample tick gk.
  task automatic send(input bit sel, input logic [7:0] d, input bit pflip,
                      input logic [1:0] stops, input int gk);
    logic line[$];
    logic v;
    int cd, bp;
    cd = sel ? P_CD : N_CD;
    bp = cd * (sel ? P_OVS : N_OVS);
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(d[i]);
    if (sel) begin
      line.push_back((^d) ^ pflip);
      line.push_back(stops[0]);
      line.push_back(stops[1]);
    end else begin
      line.push_back(stops[0]);
    end
    for (int c = 0; c < line.size() * bp; c++) begin
      v = line[c / bp];
      if (gk > 0 && c > (gk - 1) * cd && c <= gk * cd) v = ~v;
      drive(sel, v);
      step();
    end
  endtask

  task automatic wait_rec(input bit sel, input int n);
    for (int t = 0; t < n && qsize(sel) == 0; t++) step();
  endtask

  // Frame model: even parity flags when data XOR parity bit is 1; any low stop flags framing.
  function automatic rec_t ref_frame(input bit sel, input logic [7:0] d, input bit pflip,
                                     input logic [1:0] stops);
    rec_t r;
    logic pbit;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    pbit = logic'(ones % 2) ^ pflip;
    r.d  = d;
    r.pe = sel ? (((ones + int'(pbit)) % 2) == 1) : 1'b0;
    r.fe = sel ? (stops != 2'b11) : ~stops[0];
    return r;
  endfunction

  initial begin
    vec_t vt[7];
    rec_t r, e;
    int v0, o0, op0;
    bit sel;
    logic [7:0] d;
    bit pflip;
    logic [1:0] stops;

    vt[0] = '{0, 8'h55, 0, 2'b11, 0,       8'h55,      0, 0};
    vt[1] = '{1, 8'hA5, 1, 2'b11, 0,       8'hA5,      1, 0};
    vt[2] = '{1, 8'hA5, 0, 2'b11, 0,       8'hA5,      0, 0};
    vt[3] = '{0, 8'hF0, 0, 2'b11, GK_BIT3, GLITCH_EXP, 0, 0};
    vt[4] = '{1, 8'h3C, 0, 2'b01, 0,       8'h3C,      0, 1};
    vt[5] = '{1, 8'h81, 1, 2'b11, 0,       8'h81,      1, 0};
    vt[6] = '{0, 8'hC3, 0, 2'b00, 0,       8'hC3,      0, 1};

    repeat (3) step();
    chk("rst data_n", data_n, 0);
    chk("rst valid_n", vld_n, 0);
    chk("rst perr_n", pe_n, 0);
    chk("rst ferr_n", fe_n, 0);
    chk("rst ovr_n", ov_n, 0);
    chk("rst data_p", data_p, 0);
    chk("rst valid_p", vld_p, 0);
    chk("rst perr_p", pe_p, 0);
    chk("rst ferr_p", fe_p, 0);
    chk("rst ovr_p", ov_p, 0);
    Reset = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 7; i++) begin
      got_n.delete();
      got_p.delete();
      v0 = vcyc_n;
      send(vt[i].sel, vt[i].d, vt[i].pflip, vt[i].stops, vt[i].gk);
      idle(vt[i].sel, 8);
      wait_rec(vt[i].sel, 200);
      chk($sformatf("vec%0d count", i), qsize(vt[i].sel), 1);
      if (qsize(vt[i].sel) > 0) begin
        r = first(vt[i].sel);
        chk($sformatf("vec%0d data", i), r.d, vt[i].exp_d);
        chk($sformatf("vec%0d perr", i), r.pe, vt[i].exp_pe);
        chk($sformatf("vec%0d ferr", i), r.fe, vt[i].exp_fe);
      end
      if (!vt[i].sel) chk($sformatf("vec%0d valid cycles", i), vcyc_n - v0, 1);
    end

    // Low stop bit with the line held low for 40 ticks: one error frame, no retrigger.
    got_n.delete();
    send(0, 8'h00, 0, 2'b00, 0);
    drive(0, 1'b0);
    repeat (40 * N_CD) step();
    chk("break count", got_n.size(), 1);
    if (got_n.size() > 0) begin
      chk("break data", got_n[0].d, 8'h00);
      chk("break ferr", got_n[0].fe, 1);
    end
    idle(0, 300);
    chk("break no retrigger", got_n.size(), 1);

    // Start bit only 3 ticks long is rejected; the next frame is clean.
    drive(0, 1'b0);
    repeat (3 * N_CD) step();
    idle(0, 300);
    chk("false start", got_n.size(), 1);
    send(0, 8'h3C, 0, 2'b11, 0);
    idle(0, 8);
    wait_rec(0, 200);
    chk("after false start count", got_n.size(), 2);
    if (got_n.size() > 1) chk("after false start data", got_n[1].d, 8'h3C);

    // Overrun: second frame dropped while the first is held.
    got_n.delete();
    rdy_n = 1'b0;
    o0 = ovr_n;
    send(0, 8'h11, 0, 2'b11, 0);
    idle(0, 24);
    send(0, 8'h22, 0, 2'b11, 0);
    idle(0, 48);
    chk("ovr pulse cycles", ovr_n - o0, 1);
    chk("ovr valid held", vld_n, 1);
    chk("ovr data held", data_n, 8'h11);
    rdy_n = 1'b1;
    step();
    chk("ovr valid drop", vld_n, 0);
    chk("ovr accepted", got_n.size(), 1);
    if (got_n.size() > 0) chk("ovr accepted data", got_n[0].d, 8'h11);

    // Reset in the middle of a frame aborts it.
    drive(0, 1'b0);
    repeat (N_CD * N_OVS) step();
    drive(0, 1'b1);
    repeat (30) step();
    Reset = 1'b1;
    repeat (2) step();
    chk("midrst valid", vld_n, 0);
    chk("midrst data", data_n, 0);
    Reset = 1'b0;
    idle(0, 48);
    got_n.delete();
    send(0, 8'h44, 0, 2'b11, 0);
    idle(0, 8);
    wait_rec(0, 200);
    chk("midrst next count", got_n.size(), 1);
    if (got_n.size() > 0) chk("midrst next data", got_n[0].d, 8'h44);

    // Random frames on both instances against the frame model.
    o0  = ovr_n;
    op0 = ovr_p;
    for (int i = 0; i < 24; i++) begin
      sel   = bit'($urandom_range(0, 1));
      d     = 8'($urandom);
      pflip = sel ? bit'($urandom_range(0, 1)) : 1'b0;
      stops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      e     = ref_frame(sel, d, pflip, stops);
      got_n.delete();
      got_p.delete();
      send(sel, d, pflip, stops, 0);
      idle(sel, 4 + int'($urandom_range(0, 30)));
      wait_rec(sel, 200);
      chk($sformatf("rnd%0d count", i), qsize(sel), 1);
      if (qsize(sel) > 0) begin
        r = first(sel);
        chk($sformatf("rnd%0d frame", i), 32'(r), 32'(e));
      end
    end
    chk("rnd no overrun n", ovr_n - o0, 0);
    chk("rnd no overrun p", ovr_p - op0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
